calculate_checksum: RTL and testbench
=====================================

// Module: calculate_checksum
//
// PURPOSE
//  Flit checksum generator/checker for the NoC datapath. Combinationally computes the
//  8-bit checksum over header+payload of a types::flit_t and flags whether the received
//  checksum field matches. Emits a copy of the flit with the computed checksum inserted.
//  Also provides a one-cycle registered copy of the results for timing-critical consumers.
//  Used on both transmit (fill checksum) and receive (verify) paths.
//
// PARAMETERS
//  none; all widths come from package types (flit_t, checksum_t = 8 bits).
//
// PORTS
//  clk          in   1              system clock (single clock domain)
//  nrst         in   1              asynchronous, active-low reset
//  flit_in      in   flit_t         flit under test (header, payload, checksum)
//  flit_in_vld  in   1              qualifies flit_in for the registered stage only
//  checksum     out  checksum_t     computed checksum of flit_in (combinational)
//  is_valid     out  1              1 when flit_in.checksum == computed checksum (comb.)
//  flit_out     out  flit_t         flit_in with checksum field = computed checksum (comb.)
//  checksum_q   out  checksum_t     registered checksum
//  is_valid_q   out  1              registered is_valid
//  flit_out_q   out  flit_t         registered flit_out
//  vld_q        out  1              registered flit_in_vld
//
// BEHAVIOUR
//  - Data bits D = {flit_in.header, flit_in.payload} (packed, checksum field excluded),
//    zero-extended at the MSB side to a multiple of 8 bits, split into bytes.
//  - checksum = bitwise XOR of all bytes of D. All-zero flit -> 8'h00.
//  - is_valid = (flit_in.checksum == checksum); flit_in.checksum itself is never XORed in.
//  - flit_out.header = flit_in.header; flit_out.payload = flit_in.payload;
//    flit_out.checksum = checksum. So when is_valid=1, flit_out == flit_in bit-exact.
//  - Comb outputs: zero latency, no dependence on clk/nrst/flit_in_vld; settle within
//    the same time step as flit_in changes.
//  - Registered stage: at posedge clk, vld_q <= flit_in_vld; when flit_in_vld=1,
//    checksum_q/is_valid_q/flit_out_q <= comb values; otherwise they hold.
//  - nrst low (async, any time): vld_q, checksum_q, is_valid_q, flit_out_q all 0
//    immediately; comb outputs unaffected by reset.
//  - Release of nrst takes effect at next posedge; no X on any output after reset.
//  - Payload union variants (e.g. nope) are treated purely as packed bits.
//
// STRUCTURE
//  - Package types: flit_t, header_t, flit_id_t, payload union, checksum_t, flittype
//    enum (NOPE, ...), CHECKSUM_WIDTH=8. No new types defined locally.
//  - One sub-module: checksum_xor_reduce (pure comb byte-XOR over packed data, width
//    generic), shared with the transmit encoder. Register stage lives in this module.
//
// TESTING
//  1. All fields 0, checksum 8'h00 -> checksum=00, is_valid=1, flit_out==flit_in.
//  2. Only lowest payload byte = 8'hA5, flit_in.checksum=00 -> checksum=A5,
//     is_valid=0, flit_out.checksum=A5, header/payload unchanged.
//  3. Same flit as 2 but flit_in.checksum=A5 -> checksum=A5, is_valid=1.
//  4. Two data bytes 8'h3C and 8'h3C -> checksum=00; bytes A5 and 5A -> checksum=FF.
//  5. nrst=0 mid-stream -> vld_q/checksum_q/is_valid_q/flit_out_q = 0 at once; comb
//     outputs still track flit_in.
//  6. flit_in_vld=1 one cycle with case 3, then 0 with case 2 -> _q outputs show
//     checksum_q=A5, is_valid_q=1 and hold; vld_q 1 then 0.

Source files
------------

// File: rtl/calculate_checksum_pkg.sv
// Shared NoC flit types and checksum widths.
package calculate_checksum_pkg;

    localparam int unsigned CHECKSUM_WIDTH = 8;

    typedef logic [CHECKSUM_WIDTH-1:0] checksum_t;

    typedef enum logic [1:0] {
        NOPE,
        HEAD,
        BODY,
        TAIL
    } flittype_t;

    typedef logic [9:0] flit_id_t;

    typedef struct packed {
        flittype_t  flit_type;
        logic [3:0] src;
        logic [3:0] dst;
        flit_id_t   id;
    } header_t;

    typedef struct packed {
        logic [31:0] reserved;
    } payload_nope_t;

    typedef union packed {
        logic [31:0]   raw;
        payload_nope_t nope;
    } payload_t;

    typedef struct packed {
        header_t   header;
        payload_t  payload;
        checksum_t checksum;
    } flit_t;

    // Header is 20 bits, so the data word is not byte-aligned and gets MSB zero padding.
    localparam int unsigned DATA_WIDTH = $bits(header_t) + $bits(payload_t);

endpackage

// File: rtl/calculate_checksum_if.sv
// Flit in / checksum results bundle for the checksum generator/checker.
interface calculate_checksum_if;
    import calculate_checksum_pkg::*;

    flit_t     flit_in;
    logic      flit_in_vld;
    checksum_t checksum;
    logic      is_valid;
    flit_t     flit_out;
    checksum_t checksum_q;
    logic      is_valid_q;
    flit_t     flit_out_q;
    logic      vld_q;

    modport master (
        output flit_in,
        output flit_in_vld,
        input  checksum,
        input  is_valid,
        input  flit_out,
        input  checksum_q,
        input  is_valid_q,
        input  flit_out_q,
        input  vld_q
    );

    modport slave (
        input  flit_in,
        input  flit_in_vld,
        output checksum,
        output is_valid,
        output flit_out,
        output checksum_q,
        output is_valid_q,
        output flit_out_q,
        output vld_q
    );

endinterface

// File: rtl/calculate_checksum_xor_reduce.sv
// Byte-wise XOR reduction over a packed vector of arbitrary width (MSB zero-padded).
module checksum_xor_reduce #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] data,
    output logic [7:0]       result
);

    localparam int unsigned NumBytes = (Width + 7) / 8;

    logic [NumBytes*8-1:0] padded;

    always_comb begin
        padded = '0;
        padded[Width-1:0] = data;
        result = 8'h00;
        for (int unsigned i = 0; i < NumBytes; i++) begin
            result = result ^ padded[i*8 +: 8];
        end
    end

endmodule

// File: rtl/calculate_checksum.sv
// Flit checksum generator/checker with a combinational result and a registered copy.
module calculate_checksum
    import calculate_checksum_pkg::*;
(
    input logic               clk,
    input logic               nrst,
    calculate_checksum_if.slave bus
);

    logic [DATA_WIDTH-1:0] data;
    checksum_t             sum;

    // Checksum field is excluded from the data word.
    assign data = {bus.flit_in.header, bus.flit_in.payload};

    checksum_xor_reduce #(
        .Width (DATA_WIDTH)
    ) u_xor_reduce (
        .data   (data),
        .result (sum)
    );

    assign bus.checksum = sum;
    assign bus.is_valid = (bus.flit_in.checksum == sum);

    always_comb begin
        bus.flit_out          = bus.flit_in;
        bus.flit_out.checksum = sum;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.vld_q      <= 1'b0;
            bus.checksum_q <= '0;
            bus.is_valid_q <= 1'b0;
            bus.flit_out_q <= '0;
        end else begin
            bus.vld_q <= bus.flit_in_vld;
            if (bus.flit_in_vld) begin
                bus.checksum_q <= sum;
                bus.is_valid_q <= bus.is_valid;
                bus.flit_out_q <= bus.flit_out;
            end
        end
    end

endmodule

// File: tb/tb_calculate_checksum.sv
// Directed self-checking bench for calculate_checksum.
module tb_calculate_checksum;
    import calculate_checksum_pkg::*;

    logic clk;
    logic nrst;
    int   checks;
    int   errors;

    calculate_checksum_if bus ();

    calculate_checksum dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic flit_t mk(input logic [19:0] h, input logic [31:0] p, input logic [7:0] c);
        logic [59:0] v;
        v = {h, p, c};
        return flit_t'(v);
    endfunction

    task automatic drive(input logic [19:0] h, input logic [31:0] p, input logic [7:0] c,
                         input logic vld);
        bus.flit_in     = mk(h, p, c);
        bus.flit_in_vld = vld;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nrst = 1'b0;
        bus.flit_in = '0;
        bus.flit_in_vld = 1'b0;
        #2;
        check("rst_vld_q", 64'(bus.vld_q), 64'd0);
        check("rst_checksum_q", 64'(bus.checksum_q), 64'h00);
        check("rst_is_valid_q", 64'(bus.is_valid_q), 64'd0);
        check("rst_flit_out_q", 64'(bus.flit_out_q), 64'd0);

        @(negedge clk);
        nrst = 1'b1;

        // 1: all zero
        drive(20'h0, 32'h0, 8'h00, 1'b0);
        check("zero_cs", 64'(bus.checksum), 64'h00);
        check("zero_valid", 64'(bus.is_valid), 64'd1);
        check("zero_fout", 64'(bus.flit_out), 64'd0);

        // 2: lowest payload byte A5, wrong checksum
        drive(20'h0, 32'h0000_00A5, 8'h00, 1'b0);
        check("a5_cs", 64'(bus.checksum), 64'hA5);
        check("a5_valid", 64'(bus.is_valid), 64'd0);
        check("a5_fout", 64'(bus.flit_out), {4'h0, 20'h0, 32'h0000_00A5, 8'hA5});

        // 3: same with correct checksum
        drive(20'h0, 32'h0000_00A5, 8'hA5, 1'b0);
        check("a5ok_cs", 64'(bus.checksum), 64'hA5);
        check("a5ok_valid", 64'(bus.is_valid), 64'd1);
        check("a5ok_fout", 64'(bus.flit_out), {4'h0, 20'h0, 32'h0000_00A5, 8'hA5});

        // 4: cancelling and complementary bytes
        drive(20'h0, 32'h0000_3C3C, 8'h00, 1'b0);
        check("3c3c_cs", 64'(bus.checksum), 64'h00);
        check("3c3c_valid", 64'(bus.is_valid), 64'd1);
        drive(20'h0, 32'h0000_5AA5, 8'h00, 1'b0);
        check("a55a_cs", 64'(bus.checksum), 64'hFF);

        // Header bytes 34,12 and padded top nibble 09
        drive(20'h91234, 32'h0, 8'h2F, 1'b0);
        check("hdr_cs", 64'(bus.checksum), 64'h2F);
        check("hdr_valid", 64'(bus.is_valid), 64'd1);
        drive(20'hABCDE, 32'h0102_0304, 8'hFF, 1'b0);
        check("mix_cs", 64'(bus.checksum), 64'h6C);
        check("mix_fout", 64'(bus.flit_out), {4'h0, 20'hABCDE, 32'h0102_0304, 8'h6C});

        // 6: register case 3, then hold through case 2 with vld low
        @(negedge clk);
        drive(20'h0, 32'h0000_00A5, 8'hA5, 1'b1);
        @(posedge clk);
        #1;
        check("reg_vld_q1", 64'(bus.vld_q), 64'd1);
        check("reg_cs_q1", 64'(bus.checksum_q), 64'hA5);
        check("reg_valid_q1", 64'(bus.is_valid_q), 64'd1);
        check("reg_fout_q1", 64'(bus.flit_out_q), {4'h0, 20'h0, 32'h0000_00A5, 8'hA5});
        @(negedge clk);
        drive(20'h0, 32'h0000_00A5, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("reg_vld_q0", 64'(bus.vld_q), 64'd0);
        check("reg_cs_hold", 64'(bus.checksum_q), 64'hA5);
        check("reg_valid_hold", 64'(bus.is_valid_q), 64'd1);
        check("reg_fout_hold", 64'(bus.flit_out_q), {4'h0, 20'h0, 32'h0000_00A5, 8'hA5});
        check("comb_after_hold", 64'(bus.is_valid), 64'd0);

        // 5: async reset mid-cycle
        @(negedge clk);
        drive(20'hABCDE, 32'h0102_0304, 8'h6C, 1'b1);
        @(posedge clk);
        #1;
        check("pre_rst_cs_q", 64'(bus.checksum_q), 64'h6C);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_vld_q", 64'(bus.vld_q), 64'd0);
        check("arst_cs_q", 64'(bus.checksum_q), 64'h00);
        check("arst_valid_q", 64'(bus.is_valid_q), 64'd0);
        check("arst_fout_q", 64'(bus.flit_out_q), 64'd0);
        drive(20'h91234, 32'h0, 8'h00, 1'b1);
        check("arst_comb_cs", 64'(bus.checksum), 64'h2F);
        check("arst_comb_valid", 64'(bus.is_valid), 64'd0);
        @(posedge clk);
        #1;
        check("arst_hold_vld_q", 64'(bus.vld_q), 64'd0);
        check("arst_hold_cs_q", 64'(bus.checksum_q), 64'h00);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_vld_q", 64'(bus.vld_q), 64'd1);
        check("post_rst_cs_q", 64'(bus.checksum_q), 64'h2F);
        check("post_rst_valid_q", 64'(bus.is_valid_q), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
